// File: rtl/cordic_hyp_engine.sv
// Iterative hyperbolic CORDIC: cosh/sinh/exp of a WI.WF angle; tanh via linear-vectoring
// division when CORDIC_HYP_DIV_EN is defined. Intended for WF <= 31.
module cordic_hyp_engine #(
  parameter int WI    = 4,
  parameter int WF    = 16,
  parameter int NITER = 16
) (
  input  logic                    iClk,
  input  logic                    iRst,
  input  logic                    iStart,
  input  logic                    iMode,
  input  logic signed [WI+WF-1:0] iZ,
  output logic                    oBusy,
  output logic                    oDone,
  output logic signed [WI+WF-1:0] oCosh,
  output logic signed [WI+WF-1:0] oSinh,
  output logic signed [WI+WF-1:0] oExp,
  output logic signed [WI+WF-1:0] oTanh,
  output logic                    oOvf
);
  localparam int W  = WI + WF;
  localparam int IW = $clog2(WF + 1);
  localparam logic [63:0] KINV64 = ((64'd1207497068 << WF) + 64'd500000000) / 64'd1000000000;
  localparam logic [63:0] OVF64  = (64'd1118 << WF) / 64'd1000;

  // atanh(2^-i) with 32 fractional bits; beyond i=10 it equals 2^-i to that precision.
  function automatic logic [63:0] atanh_q32(input int i);
    case (i)
      1:       atanh_q32 = 64'd2359251925;
      2:       atanh_q32 = 64'd1096989674;
      3:       atanh_q32 = 64'd539693625;
      4:       atanh_q32 = 64'd268785803;
      5:       atanh_q32 = 64'd134261444;
      6:       atanh_q32 = 64'd67114326;
      7:       atanh_q32 = 64'd33555115;
      8:       atanh_q32 = 64'd16777301;
      9:       atanh_q32 = 64'd8388619;
      10:      atanh_q32 = 64'd4194305;
      default: atanh_q32 = (i <= 32) ? (64'd1 << (32 - i)) : 64'd0;
    endcase
  endfunction

  logic signed [W-1:0] atanh_tab [0:WF];
  assign atanh_tab[0] = '0;
  genvar gi;
  generate
    for (gi = 1; gi <= WF; gi++) begin : g_atanh
      localparam logic [63:0] A32 = atanh_q32(gi);
      assign atanh_tab[gi] = W'((A32 + (64'd1 << (31 - WF))) >> (32 - WF));
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, ROT, DIV, DONE} state_t;
  state_t              state_reg;
  logic signed [W-1:0] x_reg, y_reg, z_reg;
  logic [IW-1:0]       idx_reg;
  logic                rep_reg;

  logic signed [W-1:0] x_sh, y_sh, ang, x_rot, y_rot, z_rot;
  logic                z_pos, is_rep, last_rot, ovf_next;
  logic [W:0]          z_ext, z_abs;

  always_comb begin
    x_sh     = x_reg >>> idx_reg;
    y_sh     = y_reg >>> idx_reg;
    ang      = atanh_tab[idx_reg];
    z_pos    = ~z_reg[W-1];
    x_rot    = z_pos ? x_reg + y_sh : x_reg - y_sh;
    y_rot    = z_pos ? y_reg + x_sh : y_reg - x_sh;
    z_rot    = z_pos ? z_reg - ang  : z_reg + ang;
    is_rep   = (int'(idx_reg) == 4) || (int'(idx_reg) == 13) || (int'(idx_reg) == 40);
    last_rot = (int'(idx_reg) == NITER) && !(is_rep && !rep_reg);
    z_ext    = {iZ[W-1], iZ};
    z_abs    = z_ext[W] ? (~z_ext + 1'b1) : z_ext;
    ovf_next = z_abs > OVF64[W:0];
  end

`ifdef CORDIC_HYP_DIV_EN
  localparam logic [W-1:0] ONE = W'(64'd1 << WF);
  logic signed [W-1:0] r_reg, q_reg, tanh_reg, r_div, q_div, q_step;
  logic                mode_reg, last_div;

  // Residual r is driven toward zero while q accumulates r0/x, i.e. sinh/cosh.
  always_comb begin
    q_step   = ONE >> idx_reg;
    r_div    = r_reg[W-1] ? r_reg + x_sh   : r_reg - x_sh;
    q_div    = r_reg[W-1] ? q_reg - q_step : q_reg + q_step;
    last_div = int'(idx_reg) == NITER - 1;
  end
  assign oTanh = tanh_reg;
`else
  logic mode_unused;
  assign mode_unused = iMode;
  assign oTanh       = '0;
`endif

  always_ff @(posedge iClk) begin
    if (!iRst) begin
      state_reg <= IDLE;
      x_reg     <= '0;
      y_reg     <= '0;
      z_reg     <= '0;
      idx_reg   <= '0;
      rep_reg   <= 1'b0;
      oBusy     <= 1'b0;
      oDone     <= 1'b0;
      oOvf      <= 1'b0;
      oCosh     <= '0;
      oSinh     <= '0;
      oExp      <= '0;
`ifdef CORDIC_HYP_DIV_EN
      r_reg     <= '0;
      q_reg     <= '0;
      tanh_reg  <= '0;
      mode_reg  <= 1'b0;
`endif
    end else begin
      oDone <= 1'b0;
      case (state_reg)
        IDLE: if (iStart) begin
          x_reg     <= KINV64[W-1:0];
          y_reg     <= '0;
          z_reg     <= iZ;
          idx_reg   <= IW'(1);
          rep_reg   <= 1'b0;
          oOvf      <= ovf_next;
          oBusy     <= 1'b1;
          state_reg <= ROT;
`ifdef CORDIC_HYP_DIV_EN
          mode_reg  <= iMode;
`endif
        end
        ROT: begin
          x_reg <= x_rot;
          y_reg <= y_rot;
          z_reg <= z_rot;
          // Repeated indices run twice to keep the hyperbolic sequence convergent.
          if (is_rep && !rep_reg) begin
            rep_reg <= 1'b1;
          end else begin
            rep_reg <= 1'b0;
            idx_reg <= idx_reg + 1'b1;
          end
          if (last_rot) begin
`ifdef CORDIC_HYP_DIV_EN
            if (mode_reg) begin
              state_reg <= DIV;
              idx_reg   <= '0;
              r_reg     <= y_rot;
              q_reg     <= '0;
            end else
`endif
            begin
              state_reg <= DONE;
              oCosh     <= x_rot;
              oSinh     <= y_rot;
              oExp      <= x_rot + y_rot;
`ifdef CORDIC_HYP_DIV_EN
              tanh_reg  <= '0;
`endif
            end
          end
        end
`ifdef CORDIC_HYP_DIV_EN
        DIV: begin
          r_reg   <= r_div;
          q_reg   <= q_div;
          idx_reg <= idx_reg + 1'b1;
          if (last_div) begin
            state_reg <= DONE;
            oCosh     <= x_reg;
            oSinh     <= y_reg;
            oExp      <= x_reg + y_reg;
            tanh_reg  <= q_div;
          end
        end
`endif
        DONE: begin
          oDone     <= 1'b1;
          oBusy     <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cordic_hyp_engine.sv
// Directed bench for cordic_hyp_engine at default parameters (Q4.16); expectations
// for tanh and mode-1 latency follow whether CORDIC_HYP_DIV_EN is defined.
module tb_cordic_hyp_engine;
  localparam int WI = 4, WF = 16, NITER = 16, W = WI + WF;
`ifdef CORDIC_HYP_DIV_EN
  localparam bit DIVEN = 1'b1;
`else
  localparam bit DIVEN = 1'b0;
`endif
  localparam int LAT0 = 19;
  localparam int LAT1 = DIVEN ? 35 : 19;
  localparam int TOL  = 16;

  logic iClk = 1'b0, iRst = 1'b0, iStart = 1'b0, iMode = 1'b0;
  logic signed [W-1:0] iZ = '0;
  logic oBusy, oDone, oOvf;
  logic signed [W-1:0] oCosh, oSinh, oExp, oTanh;

  int checks = 0, failures = 0;
  int lat, cnt, first, second;

  cordic_hyp_engine #(.WI(WI), .WF(WF), .NITER(NITER)) dut (
    .iClk(iClk), .iRst(iRst), .iStart(iStart), .iMode(iMode), .iZ(iZ),
    .oBusy(oBusy), .oDone(oDone), .oCosh(oCosh), .oSinh(oSinh),
    .oExp(oExp), .oTanh(oTanh), .oOvf(oOvf)
  );

  always #5 iClk = ~iClk;

  task automatic check_eq(input string tag, input longint act, input longint exp);
    checks++;
    assert (act === exp) else begin
      failures++;
      $error("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic check_tol(input string tag, input longint act, input longint exp);
    longint diff;
    diff = act - exp;
    if (diff < 0) diff = -diff;
    checks++;
    assert ((diff <= TOL) === 1'b1) else begin
      failures++;
      $error("FAIL %s: got %0d expected %0d +/- %0d", tag, act, exp, TOL);
    end
  endtask

  task automatic start_op(input logic signed [W-1:0] z, input logic m);
    @(negedge iClk);
    iStart = 1'b1; iZ = z; iMode = m;
    @(posedge iClk);
    @(negedge iClk);
    iStart = 1'b0;
  endtask

  task automatic wait_done(output int l);
    l = 0;
    do begin
      @(posedge iClk); #1; l++;
    end while (!oDone && l < 100);
    $display("op z=%0d mode=%0b lat=%0d cosh=%0d sinh=%0d exp=%0d tanh=%0d ovf=%0b",
             iZ, iMode, l, oCosh, oSinh, oExp, oTanh, oOvf);
  endtask

  task automatic watch_done(input int n, output int c);
    c = 0;
    repeat (n) begin
      @(posedge iClk); #1;
      if (oDone) c++;
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check_eq({tag, "_busy"}, oBusy, 0);
    check_eq({tag, "_done"}, oDone, 0);
    check_eq({tag, "_ovf"},  oOvf,  0);
    check_eq({tag, "_cosh"}, oCosh, 0);
    check_eq({tag, "_sinh"}, oSinh, 0);
    check_eq({tag, "_exp"},  oExp,  0);
    check_eq({tag, "_tanh"}, oTanh, 0);
  endtask

  initial begin
    repeat (3) @(posedge iClk);
    #1;
    check_zero_outputs("reset");
    @(negedge iClk); iRst = 1'b1;

    // z = 0, rotation + division
    start_op(20'sd0, 1'b1);
    wait_done(lat);
    check_eq("z0_lat", lat, LAT1);
    check_tol("z0_cosh", oCosh, 65536);
    check_tol("z0_sinh", oSinh, 0);
    check_tol("z0_tanh", oTanh, 0);
    check_eq("z0_ovf", oOvf, 0);
    check_eq("z0_busy", oBusy, 0);

    // z = 0.5, rotation + division
    start_op(20'sd32768, 1'b1);
    wait_done(lat);
    check_eq("zh_lat", lat, LAT1);
    check_tol("zh_cosh", oCosh, 73900);
    check_tol("zh_sinh", oSinh, 34151);
    check_tol("zh_exp", oExp, 108051);
    check_tol("zh_tanh", oTanh, DIVEN ? 30285 : 0);
    check_eq("zh_ovf", oOvf, 0);
    watch_done(1, cnt);
    check_eq("zh_pulse_width", cnt, 0);

    // z = -1.0, rotation only
    start_op(-20'sd65536, 1'b0);
    wait_done(lat);
    check_eq("zm1_lat", lat, LAT0);
    check_tol("zm1_sinh", oSinh, -77018);
    check_tol("zm1_cosh", oCosh, 101127);
    check_tol("zm1_exp", oExp, 24109);
    check_eq("zm1_tanh", oTanh, 0);

    // out of convergence range, then back in range
    start_op(20'sd98304, 1'b0);
    wait_done(lat);
    check_eq("z15_lat", lat, LAT0);
    check_eq("z15_ovf", oOvf, 1);
    start_op(20'sd16384, 1'b0);
    wait_done(lat);
    check_eq("zq_ovf", oOvf, 0);
    check_tol("zq_cosh", oCosh, 67595);
    check_tol("zq_sinh", oSinh, 16555);

    // overflow threshold edges: 1.118 lies between 73269 and 73270 LSBs
    start_op(20'sd73270, 1'b0);
    wait_done(lat);
    check_eq("ovf_pos_edge", oOvf, 1);
    start_op(-20'sd73270, 1'b0);
    wait_done(lat);
    check_eq("ovf_neg_edge", oOvf, 1);
    start_op(20'sd73269, 1'b0);
    wait_done(lat);
    check_eq("ovf_in_range", oOvf, 0);

    // iStart re-pulsed during ROT with a different angle must be ignored
    start_op(20'sd32768, 1'b0);
    repeat (4) @(negedge iClk);
    iStart = 1'b1; iZ = -20'sd65536;
    @(negedge iClk);
    iStart = 1'b0;
    wait_done(lat);
    check_eq("repulse_lat", lat, LAT0 - 5);
    check_tol("repulse_cosh", oCosh, 73900);
    check_tol("repulse_sinh", oSinh, 34151);
    watch_done(40, cnt);
    check_eq("repulse_extra_done", cnt, 0);

    // reset during ROT cycle 5 aborts silently
    start_op(20'sd32768, 1'b0);
    repeat (4) @(negedge iClk);
    iRst = 1'b0;
    @(posedge iClk); #1;
    check_zero_outputs("abort");
    @(negedge iClk); iRst = 1'b1;
    watch_done(30, cnt);
    check_eq("abort_no_done", cnt, 0);
    start_op(-20'sd32768, 1'b0);
    wait_done(lat);
    check_eq("post_abort_lat", lat, LAT0);
    check_tol("post_abort_sinh", oSinh, -34151);
    check_tol("post_abort_cosh", oCosh, 73900);

    // iStart held high: ignored in DONE, captured in the IDLE cycle after
    @(negedge iClk);
    iStart = 1'b1; iZ = 20'sd16384; iMode = 1'b0;
    @(posedge iClk);
    first = 0; second = 0;
    for (int e = 1; e <= 60 && second == 0; e++) begin
      @(posedge iClk); #1;
      if (oDone) begin
        if (first == 0) first = e;
        else second = e;
      end
    end
    @(negedge iClk); iStart = 1'b0;
    $display("op held-start z=%0d first_done=%0d second_done=%0d", iZ, first, second);
    check_eq("held_first_done", first, LAT0);
    check_eq("held_second_done", second, 2 * LAT0 + 1);
    watch_done(25, cnt);
    check_eq("held_no_third", cnt, 0);
    check_eq("held_idle_busy", oBusy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cordic_hyp_engine.md
CORDIC_HYP_ENGINE -- requirements
Module: cordic_hyp_engine

Interface
REQ-001 SHALL have parameter WI, default 4: signed integer bits of every data port, sign bit included.
REQ-002 SHALL have parameter WF, default 16: fractional bits of every data port; W = WI+WF.
REQ-003 SHALL have parameter NITER, default 16: hyperbolic iterations i = 1..NITER, and division iterations (3 <= NITER <= WF).
REQ-004 SHALL have port iClk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port iRst, input, 1 bit: synchronous, active-low reset.
REQ-006 SHALL have port iStart, input, 1: request; sampled only in IDLE.
REQ-007 SHALL have port iMode, input, 1: 0 = rotation only (cosh/sinh/exp); 1 = rotation plus tanh division.
REQ-008 SHALL have port iZ, input, W signed: angle, captured with iStart.
REQ-009 SHALL have port oBusy, input-independent output, 1: high in every state except IDLE.
REQ-010 SHALL have port oDone, output, 1: one-cycle pulse when results are valid.
REQ-011 SHALL have ports oCosh, oSinh, oExp, oTanh, outputs, W signed each: results.
REQ-012 SHALL have port oOvf, output, 1: |iZ| > 1.118 at capture (outside convergence range).

Function
REQ-013 SHALL use FSM states IDLE, ROT, DIV, DONE; IDLE->ROT on iStart; ROT->DIV (iMode=1) or ROT->DONE (iMode=0) after last rotation step; DIV->DONE after NITER steps; DONE->IDLE unconditionally.
REQ-014 SHALL, on capture, load x = 1/Kh (1.2074970677 rounded to WF bits), y = 0, z = iZ, latch iMode, and set oOvf.
REQ-015 SHALL, in ROT, perform per cycle x+=d*(y>>>i), y+=d*(x>>>i), z-=d*atanh(2^-i), d = +1 if z >= 0 else -1, using pre-update x/y.
REQ-016 SHALL repeat iterations i = 4, 13, 40 (each once, when <= NITER); rotation cycle count NROT = NITER + repeats (18 at defaults).
REQ-017 SHALL hold atanh(2^-i) in a constant table of WF-bit-rounded values for i = 1..WF.
REQ-018 SHALL, in DIV step j = 0..NITER-1, run linear vectoring with x fixed: d = +1 if y >= 0 else -1; y -= d*(x>>>j); q += d*2^-j; q starts 0.
REQ-019 SHALL use arithmetic right shift, two's-complement W-bit wrap (no saturation) in datapath.
REQ-020 SHALL register oCosh = x, oSinh = y, oExp = x+y, oTanh = q (0 when iMode=0) on entering DONE; outputs hold until next capture.
REQ-021 SHALL assert oDone exactly NROT+1 cycles after the iStart sampling edge (mode 0), NROT+NITER+1 (mode 1).
REQ-022 SHALL ignore iStart while oBusy = 1; iStart high in DONE is not captured; iStart high in IDLE the cycle after DONE is captured.
REQ-023 SHALL still compute and complete normally when oOvf = 1 (results not guaranteed).

Reset
REQ-024 SHALL, with iRst = 0 at a clock edge, enter IDLE and clear all outputs to 0 (oBusy, oDone, oOvf, oCosh, oSinh, oExp, oTanh), from any state including mid-ROT/DIV.
REQ-025 SHALL not produce oDone for an operation aborted by reset.

Configuration
REQ-026 SHALL, when macro CORDIC_HYP_DIV_EN is defined, include the DIV state and division datapath.
REQ-027 SHALL, without CORDIC_HYP_DIV_EN, omit DIV logic, treat iMode as 0, and tie oTanh to 0.

Verification
REQ-028 SHALL cover: reset, iZ = 0, iMode = 1 -> oCosh = 0x10000 +/-2^-12, oSinh = 0, oTanh = 0, oDone at cycle 35 (defaults).
REQ-029 SHALL cover: iZ = 0.5, iMode = 1 -> oCosh 1.1276, oSinh 0.5211, oExp 1.6487, oTanh 0.4621, all +/-2^-12, oOvf = 0.
REQ-030 SHALL cover: iZ = -1.0, iMode = 0 -> oSinh -1.1752, oCosh 1.5431, oTanh = 0, oDone at cycle 19.
REQ-031 SHALL cover: iZ = 1.5 -> oOvf = 1, oDone still pulses; next start with iZ = 0.25 -> oOvf = 0.
REQ-032 SHALL cover: iStart re-pulsed mid-ROT with new iZ -> ignored, results match first iZ, single oDone.
REQ-033 SHALL cover: iRst low at ROT cycle 5 -> all outputs 0 next cycle, no oDone; new start completes correctly.
